// File: rtl/uart_pkg.sv
// Shared constants and elaboration-time helpers for the UART baud generator:
// reset divisor rounding, oversample legality and counter widths.
package uart_pkg;

    localparam int OS_MIN = 2;
    localparam int OS_MAX = 64;

    // Divisor in units of 1/2^frac_w clocks, rounded to the nearest unit.
    function automatic longint rst_div(
        input longint clk_hz,
        input longint baud,
        input longint oversample,
        input int     frac_w
    );
        longint num;
        longint den;
        num = clk_hz << frac_w;
        den = baud * oversample;
        return (num + num + den) / (den + den);
    endfunction

    function automatic bit os_legal(input int oversample);
        return (oversample >= OS_MIN) && (oversample <= OS_MAX) &&
               ((oversample & (oversample - 1)) == 0);
    endfunction

    function automatic int os_width(input int oversample);
        return $clog2(oversample);
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional period counter: div_int clocks per period, stretched by one
// clock whenever the phase accumulator carried on the previous tick.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] next_frac,
    output logic              tick
);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  eff_int;
    logic [DIV_W-1:0]  lim;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [FRAC_W:0]   acc_sum;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        eff_int = (div_int == '0) ? DIV_W'(1) : div_int;
        lim     = eff_int - DIV_W'(1) + DIV_W'(carry);
        acc_sum = {1'b0, acc} + {1'b0, next_frac};
        // NOTE: tick is decoded from registered state; the top registers it, so
        // rxclk_en appears in the cycle after the counter wraps.
        tick    = en && !clr && (cnt == lim);
    end

    // The frac added at a wrap belongs to the period that starts there, so a
    // divisor swapped in at the wrap decides its own first stretch.
    always_ff @(posedge clk_50m) begin
        if (rst || clr) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            acc   <= acc_sum[FRAC_W-1:0];
            carry <= acc_sum[FRAC_W];
        end else if (en) begin
            cnt   <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud tick generator: fractional rx oversample tick, tx bit tick every
// OVERSAMPLE rx ticks, and a shadowed divisor applied only at period wraps.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              rxclk_en,
    output logic              txclk_en,
    output logic              div_pending
);

    localparam int                OS_W     = os_width(OVERSAMPLE);
    localparam longint            RST_DIV  = rst_div(longint'(CLK_HZ), longint'(BAUD),
                                                     longint'(OVERSAMPLE), FRAC_W);
    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RST_DIV >> FRAC_W);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);

    if (!os_legal(OVERSAMPLE)) begin : g_bad_oversample
        $error("uart_baud_gen: OVERSAMPLE=%0d must be a power of two in 2..64", OVERSAMPLE);
    end

    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  shd_int;
    logic [FRAC_W-1:0] shd_frac;
    logic [DIV_W-1:0]  load_int;
    logic [FRAC_W-1:0] load_frac;
    logic [FRAC_W-1:0] next_frac;
    logic              pending;
    logic              have_new;
    logic              apply_now;
    logic              raw_tick;
    logic [OS_W-1:0]   os_cnt;

    // A load arriving on the wrap cycle itself is treated as already pending.
    always_comb begin
        load_int  = div_load ? div_int  : shd_int;
        load_frac = div_load ? div_frac : shd_frac;
        have_new  = div_load || pending;
        next_frac = have_new ? load_frac : act_frac;
        apply_now = (sync_clr && div_load) || (raw_tick && have_new);
    end

    uart_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .en        (en),
        .clr       (sync_clr),
        .div_int   (act_int),
        .next_frac (next_frac),
        .tick      (raw_tick)
    );

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            act_int  <= RST_INT;
            act_frac <= RST_FRAC;
            shd_int  <= RST_INT;
            shd_frac <= RST_FRAC;
            pending  <= 1'b0;
            os_cnt   <= '0;
            rxclk_en <= 1'b0;
            txclk_en <= 1'b0;
        end else begin
            rxclk_en <= raw_tick;
            txclk_en <= raw_tick && (os_cnt == OS_LAST);

            if (sync_clr) begin
                os_cnt <= '0;
            end else if (raw_tick) begin
                os_cnt <= os_cnt + OS_W'(1);
            end

            if (div_load) begin
                shd_int  <= div_int;
                shd_frac <= div_frac;
            end

            if (apply_now) begin
                act_int  <= load_int;
                act_frac <= load_frac;
                pending  <= 1'b0;
            end else if (div_load) begin
                pending  <= 1'b1;
            end
        end
    end

    assign div_pending = pending;

endmodule
